// File: rtl/adder_arbiter_if.sv
// Request/adder/response bundle for adder_arbiter.
// The arbiter connects through the slave modport; the environment
// (requesters, shared adder and response consumer) uses the master modport.
interface adder_arbiter_if;
    // requester side: four requesters, 32-bit operands packed by index
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;

    // shared 32-bit adder
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_s;
    logic         add_cout;

    // response side
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
        output req_ready, add_a, add_b, add_cin,
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, add_cin,
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one external 32-bit adder
// among four requesters. One operation is in flight at a time; the adder
// result is sampled ADD_LAT cycles after the operands are launched and held
// in a response register until the consumer accepts it.
// Optional feature: define ADDER_ARB_OVF_EN to build the signed-overflow
// flag on rsp_ovf; otherwise rsp_ovf is tied to 0.
module adder_arbiter #(
    parameter int unsigned ADD_LAT = 1  // adder latency in cycles, legal 1..7
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [2:0]  cnt;
    logic [1:0]  grant_idx;
    logic        grant_vld;
    logic        xfer;
    logic        capture;
    logic [31:0] add_a_q;
    logic [31:0] add_b_q;
    logic        add_cin_q;
    logic [1:0]  id_q;
    logic [31:0] sum_q;
    logic        cout_q;

    // Round-robin search: first valid requester at ptr, ptr+1, ... mod 4
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!grant_vld && bus.req_valid[ptr + 2'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = ptr + 2'(k);
            end
        end
    end

    // Grants only in IDLE and never while reset is asserted
    assign bus.req_ready = (state == IDLE && grant_vld && !rst)
                         ? (4'b0001 << grant_idx) : 4'b0000;
    assign xfer    = |(bus.req_valid & bus.req_ready);
    assign capture = (state == BUSY) && (cnt == 3'd1);

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (xfer)          state_nxt = BUSY;
            BUSY:    if (cnt == 3'd1)   state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand launch, latency counter, pointer and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            cnt       <= 3'd0;
            add_a_q   <= 32'd0;
            add_b_q   <= 32'd0;
            add_cin_q <= 1'b0;
            id_q      <= 2'd0;
            sum_q     <= 32'd0;
            cout_q    <= 1'b0;
        end else begin
            if (xfer) begin
                add_a_q   <= bus.req_a[grant_idx*32 +: 32];
                add_b_q   <= bus.req_b[grant_idx*32 +: 32];
                add_cin_q <= bus.req_cin[grant_idx];
                id_q      <= grant_idx;
                ptr       <= grant_idx + 2'd1;
                cnt       <= 3'(ADD_LAT);
            end else if (state == BUSY) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                sum_q  <= bus.add_s;
                cout_q <= bus.add_cout;
            end
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic ovf_q;

    // Signed overflow: like-signed operands whose sum flips sign
    always_ff @(posedge clk) begin
        if (rst)          ovf_q <= 1'b0;
        else if (capture) ovf_q <= (add_a_q[31] == add_b_q[31]) &&
                                   (bus.add_s[31] != add_a_q[31]);
    end

    assign bus.rsp_ovf = ovf_q;
`else
    assign bus.rsp_ovf = 1'b0;
`endif

    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;

endmodule
